// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the video RAM arbiter.
//   owner_t     - which requester owns a RAM slot travelling down the read pipeline.
//   cpu_state_t - CPU request handshake state.
//   VID_LATENCY - cycles from grant to vid_valid / cpu_ack.
package vram_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      VID  = 2'd1,
      CPU  = 2'd2
   } owner_t;

   typedef enum logic [1:0] {
      C_IDLE   = 2'd0,
      C_PEND   = 2'd1,
      C_FLIGHT = 2'd2
   } cpu_state_t;

   localparam int unsigned VID_LATENCY = 3;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port synchronous video RAM between the video fetcher
// (read-only, absolute priority, fixed 3-cycle latency) and the 6809 CPU bus (req/ack).
// Also records the worst CPU grant wait of each frame.
//
// Ports:
//   logic_clock, reset          - sole clock; synchronous active-high reset
//   vid_req/vid_addr            - video read request pulse and address
//   vid_valid/vid_data          - video read data, exactly 3 cycles after vid_req
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata                   - CPU request level and transaction, held until cpu_ack
//   cpu_ack/cpu_rdata           - CPU completion pulse and read data (held between reads)
//   ram_addr/ram_we/ram_wdata   - registered RAM command
//   ram_rdata                   - RAM read data, valid the cycle after ram_addr
//   frame_strobe                - one pulse per frame
//   max_stall                   - worst CPU wait of the previous frame, in cycles
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned AW    = 16,
   parameter int unsigned DW    = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             logic_clock,
   input  logic             reset,
   input  logic             vid_req,
   input  logic [AW-1:0]    vid_addr,
   output logic             vid_valid,
   output logic [DW-1:0]    vid_data,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [AW-1:0]    cpu_addr,
   input  logic [DW-1:0]    cpu_wdata,
   output logic             cpu_ack,
   output logic [DW-1:0]    cpu_rdata,
   output logic [AW-1:0]    ram_addr,
   output logic             ram_we,
   output logic [DW-1:0]    ram_wdata,
   input  logic [DW-1:0]    ram_rdata,
   input  logic             frame_strobe,
   output logic [CNT_W-1:0] max_stall
);

   // Last cycle index of the CPU in-flight window (grant+1 .. grant+VID_LATENCY).
   localparam logic [1:0] FlightLast = 2'(VID_LATENCY - 1);

   // ---------------------------------------------------------------------------------------
   // CPU FSM and slot selection
   // ---------------------------------------------------------------------------------------
   cpu_state_t state_q, state_d;
   logic [1:0] flight_cnt_q, flight_cnt_d;

   logic   cpu_avail;
   logic   vid_grant;
   logic   cpu_grant;
   logic   cpu_stall;
   owner_t grant_owner;

   always_ff @(posedge logic_clock) begin
      if (reset) begin
         state_q      <= C_IDLE;
         flight_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         flight_cnt_q <= flight_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      flight_cnt_d = flight_cnt_q;
      unique case (state_q)
         C_IDLE, C_PEND: begin
            if (cpu_grant) begin
               state_d      = C_FLIGHT;
               flight_cnt_d = '0;
            end else if (cpu_req) begin
               state_d = C_PEND;
            end else begin
               // A pending request that drops is abandoned without an ack.
               state_d = C_IDLE;
            end
         end
         C_FLIGHT: begin
            if (flight_cnt_q == FlightLast) begin
               state_d = C_IDLE;
            end else begin
               flight_cnt_d = flight_cnt_q + 2'd1;
            end
         end
         default: begin
            state_d      = C_IDLE;
            flight_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      cpu_avail   = (state_q == C_IDLE) || (state_q == C_PEND);
      vid_grant   = vid_req;
      cpu_grant   = !vid_req && cpu_req && cpu_avail;
      cpu_stall   = cpu_req && cpu_avail && !cpu_grant;
      grant_owner = NONE;
      if (vid_grant) begin
         grant_owner = VID;
      end else if (cpu_grant) begin
         grant_owner = CPU;
      end
   end

   // ---------------------------------------------------------------------------------------
   // RAM command register and read-return pipeline
   // ---------------------------------------------------------------------------------------
   logic [AW-1:0] ram_addr_q;
   logic          ram_we_q;
   logic [DW-1:0] ram_wdata_q;
   owner_t        tag1_q, tag2_q;
   logic          tag1_we_q, tag2_we_q;
   logic          vid_valid_q;
   logic [DW-1:0] vid_data_q;
   logic          cpu_ack_q;
   logic [DW-1:0] cpu_rdata_q;

   always_ff @(posedge logic_clock) begin
      if (reset) begin
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         tag1_q      <= NONE;
         tag1_we_q   <= 1'b0;
         tag2_q      <= NONE;
         tag2_we_q   <= 1'b0;
      end else begin
         // Only a CPU write grant drives the write enable, and only for one cycle.
         ram_we_q <= cpu_grant && cpu_we;
         if (vid_grant) begin
            ram_addr_q <= vid_addr;
         end else if (cpu_grant) begin
            ram_addr_q  <= cpu_addr;
            ram_wdata_q <= cpu_wdata;
         end
         tag1_q    <= grant_owner;
         tag1_we_q <= cpu_grant && cpu_we;
         tag2_q    <= tag1_q;
         tag2_we_q <= tag1_we_q;
      end
   end

   always_ff @(posedge logic_clock) begin
      if (reset) begin
         vid_valid_q <= 1'b0;
         vid_data_q  <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         vid_valid_q <= (tag2_q == VID);
         if (tag2_q == VID) begin
            vid_data_q <= ram_rdata;
         end
         cpu_ack_q <= (tag2_q == CPU);
         // Writes ack too, but leave the last read data untouched.
         if ((tag2_q == CPU) && !tag2_we_q) begin
            cpu_rdata_q <= ram_rdata;
         end
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;
   assign vid_valid = vid_valid_q;
   assign vid_data  = vid_data_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;

   // ---------------------------------------------------------------------------------------
   // Stall statistics
   // ---------------------------------------------------------------------------------------
   logic [CNT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] run_max_q, run_max_d;
   logic [CNT_W-1:0] max_stall_q, max_stall_d;
   logic [CNT_W-1:0] peak_wait;

   always_comb begin
      // wait_q already holds the full wait of a grant happening this cycle, so a snapshot
      // taken together with that grant still includes it.
      peak_wait = (wait_q > run_max_q) ? wait_q : run_max_q;

      wait_d = wait_q;
      if (cpu_grant) begin
         wait_d = '0;
      end else if (cpu_stall && (wait_q != '1)) begin
         wait_d = wait_q + 1'b1;
      end

      run_max_d = run_max_q;
      if (frame_strobe) begin
         run_max_d = '0;
      end else if (cpu_grant) begin
         run_max_d = peak_wait;
      end

      max_stall_d = frame_strobe ? peak_wait : max_stall_q;
   end

   always_ff @(posedge logic_clock) begin
      if (reset) begin
         wait_q      <= '0;
         run_max_q   <= '0;
         max_stall_q <= '0;
      end else begin
         wait_q      <= wait_d;
         run_max_q   <= run_max_d;
         max_stall_q <= max_stall_d;
      end
   end

   assign max_stall = max_stall_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level model (grant rule, model memory, scheduled completions).
module tb_vram_arbiter;

   logic        logic_clock = 1'b0;
   logic        reset;
   logic        vid_req;
   logic [15:0] vid_addr;
   logic        vid_valid;
   logic [7:0]  vid_data;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        frame_strobe;
   logic [15:0] max_stall;

   vram_arbiter #(
      .AW    (16),
      .DW    (8),
      .CNT_W (16)
   ) dut (
      .logic_clock  (logic_clock),
      .reset        (reset),
      .vid_req      (vid_req),
      .vid_addr     (vid_addr),
      .vid_valid    (vid_valid),
      .vid_data     (vid_data),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_ack      (cpu_ack),
      .cpu_rdata    (cpu_rdata),
      .ram_addr     (ram_addr),
      .ram_we       (ram_we),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata),
      .frame_strobe (frame_strobe),
      .max_stall    (max_stall)
   );

   always #5 logic_clock = ~logic_clock;

   // Synchronous RAM; unwritten locations read as addr[7:0].
   logic [7:0] ram_mem     [65536];
   bit         ram_written [65536];
   always @(posedge logic_clock) begin
      if (ram_we === 1'b1) begin
         ram_mem[ram_addr]     <= ram_wdata;
         ram_written[ram_addr] <= 1'b1;
      end
      ram_rdata <= ram_written[ram_addr] ? ram_mem[ram_addr] : ram_addr[7:0];
   end

   // ---------------------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------------------
   logic [7:0]  mdl_mem [65536];
   bit          r_vv  [8];
   logic [7:0]  r_vd  [8];
   bit          r_ack [8];
   bit          r_rd  [8];
   logic [7:0]  r_rdv [8];
   logic [7:0]  h_vd, h_rd;
   logic        e_we;
   logic [15:0] e_addr;
   logic [7:0]  e_wdata;
   logic [15:0] e_max_stall;
   int          m_wait, m_run;
   int          m_last_cpu = -100;
   int          m_ack_at   = -1;
   int          cyc        = 0;
   int          n_chk      = 0;
   int          n_err      = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         r_vv[i]  = 1'b0;
         r_ack[i] = 1'b0;
         r_rd[i]  = 1'b0;
      end
      h_vd        = '0;
      h_rd        = '0;
      e_we        = 1'b0;
      e_addr      = '0;
      e_wdata     = '0;
      e_max_stall = '0;
      m_wait      = 0;
      m_run       = 0;
      m_last_cpu  = -100;
      m_ack_at    = -1;
   endtask

   // Applies the arbitration rules to the inputs of the current cycle.
   task automatic model_eval();
      bit free;
      bit g_cpu;
      bit stall;
      int slot;
      if (reset) begin
         model_reset();
      end else begin
         slot  = (cyc + 3) & 7;
         free  = (cyc - m_last_cpu) > 3;
         g_cpu = !vid_req && cpu_req && free;
         stall = cpu_req && free && !g_cpu;
         if (frame_strobe) e_max_stall = 16'((m_run > m_wait) ? m_run : m_wait);
         if (g_cpu) begin
            if (m_wait > m_run) m_run = m_wait;
            m_wait = 0;
         end else if (stall && m_wait < 65535) begin
            m_wait++;
         end
         if (frame_strobe) m_run = 0;
         e_we = 1'b0;
         if (vid_req) begin
            e_addr     = vid_addr;
            r_vv[slot] = 1'b1;
            r_vd[slot] = mdl_mem[vid_addr];
         end else if (g_cpu) begin
            e_addr      = cpu_addr;
            m_last_cpu  = cyc;
            m_ack_at    = cyc + 3;
            r_ack[slot] = 1'b1;
            if (cpu_we) begin
               e_we              = 1'b1;
               e_wdata           = cpu_wdata;
               mdl_mem[cpu_addr] = cpu_wdata;
            end else begin
               r_rd[slot]  = 1'b1;
               r_rdv[slot] = mdl_mem[cpu_addr];
            end
         end
      end
   endtask

   task automatic tick();
      int slot;
      @(posedge logic_clock);
      #1;
      cyc++;
      slot = cyc & 7;
      if (r_vv[slot]) h_vd = r_vd[slot];
      if (r_ack[slot] && r_rd[slot]) h_rd = r_rdv[slot];
      check_eq("vid_valid", vid_valid, r_vv[slot]);
      check_eq("vid_data", vid_data, h_vd);
      check_eq("cpu_ack", cpu_ack, r_ack[slot]);
      check_eq("cpu_rdata", cpu_rdata, h_rd);
      check_eq("ram_we", ram_we, e_we);
      check_eq("ram_addr", ram_addr, e_addr);
      if (e_we) check_eq("ram_wdata", ram_wdata, e_wdata);
      check_eq("max_stall", max_stall, e_max_stall);
      r_vv[slot]  = 1'b0;
      r_ack[slot] = 1'b0;
      r_rd[slot]  = 1'b0;
   endtask

   // One clock cycle: the CPU requester releases on its ack (or on reset), inputs are
   // applied, the model is advanced, and outputs are compared after the edge.
   task automatic run(input bit vr, input logic [15:0] va, input bit fs, input bit rs);
      if (cyc == m_ack_at) cpu_req = 1'b0;
      if (rs) cpu_req = 1'b0;
      reset        = rs;
      vid_req      = vr;
      vid_addr     = va;
      frame_strobe = fs;
      model_eval();
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run(1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic cpu_start(input bit we, input logic [15:0] addr, input logic [7:0] wd);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
   endtask

   // ---------------------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------------------
   initial begin
      logic [15:0] va;
      for (int i = 0; i < 65536; i++) mdl_mem[i] = 8'(i);
      model_reset();
      reset        = 1'b1;
      vid_req      = 1'b0;
      vid_addr     = '0;
      cpu_req      = 1'b0;
      cpu_we       = 1'b0;
      cpu_addr     = '0;
      cpu_wdata    = '0;
      frame_strobe = 1'b0;

      run(1'b0, 16'h0000, 1'b0, 1'b1);
      run(1'b0, 16'h0000, 1'b0, 1'b1);
      check_eq("rst_vid_valid", vid_valid, 1'b0);
      check_eq("rst_cpu_ack", cpu_ack, 1'b0);
      check_eq("rst_ram_we", ram_we, 1'b0);
      check_eq("rst_ram_addr", ram_addr, 16'h0000);
      check_eq("rst_max_stall", max_stall, 16'h0000);
      idle(2);

      // Video only: one request every 16 cycles.
      for (int i = 0; i < 4; i++) begin
         run(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0);
         idle(2);
         check_eq("vo_valid", vid_valid, 1'b1);
         check_eq("vo_data", vid_data, 8'(i));
         idle(13);
      end

      // CPU write then read back.
      cpu_start(1'b1, 16'h1234, 8'hA5);
      idle(1);
      check_eq("wr_ram_we", ram_we, 1'b1);
      check_eq("wr_ram_addr", ram_addr, 16'h1234);
      check_eq("wr_ram_wdata", ram_wdata, 8'hA5);
      idle(2);
      check_eq("wr_ack", cpu_ack, 1'b1);
      idle(1);
      cpu_start(1'b0, 16'h1234, 8'h00);
      idle(3);
      check_eq("rd_ack", cpu_ack, 1'b1);
      check_eq("rd_data", cpu_rdata, 8'hA5);
      idle(2);

      // Collision: video wins, CPU follows one slot later.
      cpu_start(1'b0, 16'h0401, 8'h00);
      run(1'b1, 16'h0402, 1'b0, 1'b0);
      idle(2);
      check_eq("col_vid_valid", vid_valid, 1'b1);
      check_eq("col_ack_early", cpu_ack, 1'b0);
      idle(1);
      check_eq("col_ack", cpu_ack, 1'b1);
      check_eq("col_rdata", cpu_rdata, 8'h01);
      idle(2);

      // Stall statistics: five video cycles block a held CPU request.
      cpu_start(1'b0, 16'h0010, 8'h00);
      for (int k = 0; k < 5; k++) run(1'b1, 16'h0600 + 16'(k), 1'b0, 1'b0);
      idle(6);
      run(1'b0, 16'h0000, 1'b1, 1'b0);
      check_eq("stall_max5", max_stall, 16'd5);
      idle(4);
      run(1'b0, 16'h0000, 1'b1, 1'b0);
      check_eq("stall_max0", max_stall, 16'd0);
      idle(2);

      // Write followed immediately by a video read of the same address.
      cpu_start(1'b1, 16'h0500, 8'h3C);
      idle(1);
      run(1'b1, 16'h0500, 1'b0, 1'b0);
      idle(2);
      check_eq("haz_valid", vid_valid, 1'b1);
      check_eq("haz_data", vid_data, 8'h3C);
      idle(2);

      // Reset one cycle after a CPU read grant.
      cpu_start(1'b0, 16'h0403, 8'h00);
      idle(1);
      run(1'b0, 16'h0000, 1'b0, 1'b1);
      check_eq("mid_ram_we", ram_we, 1'b0);
      check_eq("mid_cpu_rdata", cpu_rdata, 8'h00);
      check_eq("mid_vid_data", vid_data, 8'h00);
      idle(3);
      check_eq("mid_no_ack", cpu_ack, 1'b0);
      cpu_start(1'b0, 16'h0403, 8'h00);
      idle(3);
      check_eq("post_ack", cpu_ack, 1'b1);
      check_eq("post_rdata", cpu_rdata, 8'h03);
      idle(2);

      // Randomized mixed traffic.
      for (int n = 0; n < 3000; n++) begin
         if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_start(1'($urandom_range(0, 1)), 16'h0500 + 16'($urandom_range(0, 7)),
                      8'($urandom));
         end
         if ($urandom_range(0, 1) == 0) va = 16'h0500 + 16'($urandom_range(0, 7));
         else va = 16'($urandom);
         run(($urandom_range(0, 2) == 0), va, ($urandom_range(0, 63) == 0),
             ($urandom_range(0, 399) == 0));
      end
      idle(6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port video RAM between the video fetcher (read-only, hard real-time) and the 6809 CPU bus (read/write, req/ack).
- Sits between the video timing block / CPU bus glue and the RAM.
- Video has absolute priority and a fixed 3-cycle read latency. The CPU is served in any cycle the video does not claim.
- Tracks worst-case CPU stall per frame for bring-up diagnostics.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- CNT_W, 16, stall counter width.

Ports:
- logic_clock  in  1  sole clock; all requesters are synchronous to it.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  video read request, single-cycle pulse.
- vid_addr  in  AW  video read address, valid with vid_req.
- vid_valid  out  1  pulse: vid_data valid.
- vid_data  out  DW  video read data.
- cpu_req  in  1  CPU request level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  AW  CPU address, stable while cpu_req is high.
- cpu_wdata  in  DW  CPU write data, stable while cpu_req is high.
- cpu_ack  out  1  pulse: CPU transaction complete.
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack (reads only).
- ram_addr  out  AW  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DW  registered RAM write data.
- ram_rdata  in  DW  RAM data, valid the cycle after ram_addr (synchronous RAM).
- frame_strobe  in  1  one-cycle pulse per frame (vsync leading edge).
- max_stall  out  CNT_W  worst CPU grant wait of the previous frame, in cycles.

Behaviour:
Reset values:
- All outputs 0. CPU FSM in C_IDLE. Pipeline tags NONE. Running max 0.

Slot selection, cycle N (evaluated every cycle):
- vid_req=1: video is granted, regardless of CPU state.
- Otherwise, if the CPU FSM is in C_IDLE or C_PEND and cpu_req=1: CPU is granted.
- Otherwise: no grant. ram_we=0; ram_addr holds its previous value.

Pipeline:
- Edge into N+1: ram_addr/ram_we/ram_wdata take the granted request; tag1 <= {VID, CPU, NONE}.
- N+2: ram_rdata is valid; tag2 <= tag1.
- Edge into N+3:
  - tag2=VID: vid_data <= ram_rdata, vid_valid=1 for N+3 only.
  - tag2=CPU: cpu_rdata <= ram_rdata (reads only); cpu_ack=1 for N+3.
- Video latency is exactly 3 cycles with no exceptions. One grant per cycle, so video and CPU ops overlap freely in the pipeline.
- ram_we is asserted only in N+1 of a CPU write.
- A write ack also occurs at N+3, after the write has committed.
- cpu_rdata holds its value between read acks; it is not updated on writes.

CPU FSM:
- C_IDLE:
  - cpu_req=1 and granted -> C_FLIGHT.
  - cpu_req=1 and not granted (video took the slot) -> C_PEND.
- C_PEND:
  - granted -> C_FLIGHT.
  - cpu_req dropped -> C_IDLE (abandoned request, no ack).
- C_FLIGHT: counts 3 cycles. Asserts cpu_ack in the third, then -> C_IDLE.
- cpu_req is ignored while in C_FLIGHT; at most one CPU transaction is outstanding.
- Requester must deassert cpu_req in the cycle after cpu_ack unless it is starting a new transaction. A request still high then is treated as new.

Stall statistics:
- wait_cnt counts cycles with cpu_req=1 in C_IDLE/C_PEND without a grant. It saturates at all-ones and clears on grant.
- run_max <= max(run_max, wait_cnt) on every grant.
- frame_strobe: max_stall <= max(run_max, wait_cnt); run_max <= 0.
- Simultaneous grant and frame_strobe: the grant's wait is included in the snapshot.

Hazards and reset:
- Ordering is strictly per-grant. A video read of an address written by the CPU in the previous slot returns the new data, since the RAM sees the write first.
- Reset mid-operation: tags cleared and in-flight ops discarded. No vid_valid or cpu_ack is issued for them; ram_we=0 from the first reset cycle.

Decomposition:
- Package vram_pkg:
  - owner_t enum {NONE, VID, CPU}.
  - cpu_state_t {C_IDLE, C_PEND, C_FLIGHT}.
  - Constant VID_LATENCY=3.
- No sub-module; the stall statistics logic is small enough to stay inline.

Test Plan:
- Video only: vid_req pulse every 16 cycles, addr 0x0400, 0x0401, …, RAM model returns addr[7:0] -> vid_valid exactly 3 cycles after each req, vid_data 0x00, 0x01, …; cpu_ack never pulses.
- CPU write then read: write 0xA5 to 0x1234, then read 0x1234 -> ram_we pulses once with addr 0x1234 and data 0xA5; each cpu_ack arrives 3 cycles after grant; read returns cpu_rdata=0xA5.
- Collision: cpu_req and vid_req rise in the same cycle -> video granted first, vid_valid at +3; CPU granted at +1, cpu_ack at +4.
- Stall stats: vid_req high for 5 consecutive cycles while cpu_req is held, then frame_strobe -> max_stall=5; after a second frame_strobe with no contention -> max_stall=0.
- Write/read hazard: CPU write 0x3C to 0x0500 in cycle N, vid_req for 0x0500 in N+1 -> vid_data=0x3C at N+4.
- Reset mid-flight: reset asserted one cycle after a CPU read grant -> no cpu_ack, FSM in C_IDLE, ram_we=0, all outputs 0; a new read after reset completes normally.
